// File: rtl/dffram_mp.sv
// Flip-flop RAM with one write port, NRD registered read ports and a self-clearing sweep.
// Define DFFRAM_BYPASS_EN for write-first forwarding; the default build is read-first.
module dffram_mp #(
   parameter int                  DWIDTH  = 24,
   parameter int                  AWIDTH  = 8,
   parameter int                  NRD     = 2,
   parameter logic [DWIDTH-1:0]   CLR_VAL = '0
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    clr,
   input  logic                    we,
   input  logic [AWIDTH-1:0]       adr_w,
   input  logic [DWIDTH-1:0]       dat_i,
   output logic [DWIDTH-1:0]       dat_o,
   input  logic [NRD-1:0]          re,
   input  logic [NRD*AWIDTH-1:0]   adr_r,
   output logic [NRD*DWIDTH-1:0]   dat_r,
   output logic [NRD-1:0]          vld_r,
   output logic                    busy
);

   localparam int DEPTH = 1 << AWIDTH;

   typedef enum logic {CLEAR, READY} state_t;

   state_t              state, state_next;
   logic [AWIDTH-1:0]   ptr;
   logic [DWIDTH-1:0]   mem [DEPTH];
   logic [DWIDTH-1:0]   o_next;
   logic [DWIDTH-1:0]   r_next [NRD];

   assign busy = (state == CLEAR);

   // NOTE: every variable gets a default before the case so no latch is inferred.
   always_comb begin
      state_next = state;
      case (state)
         CLEAR:   if (ptr == {AWIDTH{1'b1}}) state_next = READY;
         READY:   if (clr) state_next = CLEAR;
         default: state_next = CLEAR;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= CLEAR;
         ptr   <= '0;
      end else begin
         state <= state_next;
         if (state == CLEAR)
            ptr <= ptr + 1'b1;   // wraps to 0 after the last entry
         else if (clr)
            ptr <= '0;
      end
   end

   // NOTE: the array itself has no reset; the clear sweep initialises it instead.
   always_ff @(posedge clk) begin
      if (!rst) begin
         if (state == CLEAR)
            mem[ptr] <= CLR_VAL;
         else if (we)
            mem[adr_w] <= dat_i;
      end
   end

   // Next read data, with optional forwarding of the word being written this cycle.
   always_comb begin
      o_next = mem[adr_w];
`ifdef DFFRAM_BYPASS_EN
      if (we) o_next = dat_i;
`endif
      for (int k = 0; k < NRD; k++) begin
         r_next[k] = mem[adr_r[k*AWIDTH +: AWIDTH]];
`ifdef DFFRAM_BYPASS_EN
         if (we && (adr_r[k*AWIDTH +: AWIDTH] == adr_w)) r_next[k] = dat_i;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dat_o <= '0;
         dat_r <= '0;
         vld_r <= '0;
      end else if (state == READY) begin
         dat_o <= o_next;
         for (int k = 0; k < NRD; k++) begin
            vld_r[k] <= re[k];
            if (re[k]) dat_r[k*DWIDTH +: DWIDTH] <= r_next[k];
         end
      end else begin
         vld_r <= '0;
      end
   end

endmodule

// File: doc/dffram_mp.md
DFFRAM_MP -- requirements
Module: dffram_mp

Interface
REQ-001 SHALL have parameter DWIDTH, default 24: data word width in bits.
REQ-002 SHALL have parameter AWIDTH, default 8: address width; depth is 2**AWIDTH words.
REQ-003 SHALL have parameter NRD, default 2: number of independent read ports, range 1..4.
REQ-004 SHALL have parameter CLR_VAL, default 0: DWIDTH-bit word written to every entry during clear.
REQ-005 SHALL have port clk  input  1  sole clock; all logic on its rising edge.
REQ-006 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-007 SHALL have port clr  input  1  single-cycle request to re-clear the whole memory.
REQ-008 SHALL have port we  input  1  write enable.
REQ-009 SHALL have port adr_w  input  AWIDTH  write address.
REQ-010 SHALL have port dat_i  input  DWIDTH  write data.
REQ-011 SHALL have port dat_o  output  DWIDTH  registered contents at adr_w.
REQ-012 SHALL have port re  input  NRD  per-port read enable; bit k controls port k.
REQ-013 SHALL have port adr_r  input  NRD*AWIDTH  packed read addresses; port k in bits [k*AWIDTH +: AWIDTH].
REQ-014 SHALL have port dat_r  output  NRD*DWIDTH  packed registered read data; port k in bits [k*DWIDTH +: DWIDTH].
REQ-015 SHALL have port vld_r  output  NRD  per-port read-data valid.
REQ-016 SHALL have port busy  output  1  high while clear is in progress.

Function
REQ-017 SHALL implement a two-state FSM, CLEAR and READY, plus an AWIDTH-bit clear pointer.
REQ-018 In CLEAR, each cycle SHALL write CLR_VAL to entry[ptr] and increment ptr; at ptr == 2**AWIDTH-1 it SHALL write that last entry and enter READY on the next edge.
REQ-019 A full clear SHALL take exactly 2**AWIDTH cycles; busy SHALL be 1 in CLEAR and 0 in READY.
REQ-020 In READY, clr=1 SHALL enter CLEAR with ptr=0 on the next edge; a write in the same cycle still completes.
REQ-021 clr SHALL be ignored while in CLEAR; the clear in progress is neither restarted nor extended.
REQ-022 In CLEAR, we and re SHALL be ignored: no user write, vld_r=0, and dat_r/dat_o hold their values.
REQ-023 In READY, we=1 SHALL write dat_i to entry[adr_w] at the clock edge.
REQ-024 In READY, dat_o SHALL load entry[adr_w] every cycle, 1-cycle latency, independent of we.
REQ-025 In READY, with re[k]=1, dat_r port k SHALL load entry[adr_r port k] with 1-cycle latency, and vld_r[k] SHALL be 1 in the same cycle that data appears.
REQ-026 With re[k]=0, port k data SHALL hold and vld_r[k] SHALL be 0 the next cycle.
REQ-027 Any number of ports SHALL read the same or different addresses in the same cycle without interference.
REQ-028 Read-during-write to the same address SHALL follow REQ-041/REQ-042.

Reset
REQ-029 rst=1 SHALL force state CLEAR, ptr=0, busy=1, vld_r=0, dat_r=0 and dat_o=0 at the next edge.
REQ-030 rst SHALL take priority over clr, we and re.
REQ-031 rst asserted mid-clear SHALL restart the clear from ptr=0.
REQ-032 After rst deasserts, the memory SHALL hold CLR_VAL in every entry before busy falls.

Configuration
REQ-040 SHALL compile write-to-read forwarding in only when macro DFFRAM_BYPASS_EN is defined.
REQ-041 With DFFRAM_BYPASS_EN (write-first): when we=1 in READY, dat_o SHALL load dat_i, and any port with re[k]=1 and matching address SHALL load dat_i.
REQ-042 Without DFFRAM_BYPASS_EN (read-first): dat_o and matching read ports SHALL load the old entry contents.

Verification (DWIDTH=24, AWIDTH=4, NRD=2, CLR_VAL=0)
REQ-050 Pulse rst for 1 cycle -> busy=1 for exactly 16 cycles, then 0; reads of addresses 0..15 return 0x000000 with vld_r=1.
REQ-051 Write 0xABCDEF to address 5, next cycle re[0]=1 with adr_r0=5 -> one cycle later dat_r0=0xABCDEF and vld_r[0]=1; vld_r[0]=0 the following cycle when re[0]=0.
REQ-052 Address 3 holds 0x000111; same cycle we=1, adr_w=3, dat_i=0x123456, re[1]=1, adr_r1=3 -> dat_r1=0x000111 and dat_o=0x000111 without the macro, 0x123456 for both with DFFRAM_BYPASS_EN; later read of address 3 returns 0x123456.
REQ-053 Address 7 holds 0x0000AA and address 9 holds 0x0000BB -> both ports reading 7 both return 0x0000AA; port0=7, port1=9 returns 0x0000AA and 0x0000BB in the same cycle.
REQ-054 Assert rst again at clear cycle 8 -> busy stays 1 and falls exactly 16 cycles after the second rst deasserts; clr pulsed during clear has no effect on timing.
REQ-055 In READY, write 0x555555 to address 2, pulse clr -> busy=1 for 16 cycles; we/re during busy produce no write and vld_r=0; afterwards address 2 reads 0x000000.
